// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: state encoding,
// default operand width and the bit-counter width helper.
package serial_sub_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    // Width of a counter that must hold 0 .. w-1; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/serial_sub_full_sub.sv
// One-bit full subtractor cell: D = X - Y - Bin, Bout set when a borrow is needed.
module Full_Sub (
    input  logic X,
    input  logic Y,
    input  logic Bin,
    output logic D,
    output logic Bout
);

    // Pure combinational difference and borrow for a single bit position.
    always_comb begin
        D    = X ^ Y ^ Bin;
        Bout = (~X & Y) | (~(X ^ Y) & Bin);
    end

endmodule

// File: rtl/serial_sub.sv
// Bit-serial LSB-first subtractor computing A - B - Bin over WIDTH cycles
// with a start/busy/done handshake and held result/borrow/overflow outputs.
module serial_sub
    import serial_sub_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             ovf
);

    localparam int unsigned CW = cnt_width(WIDTH);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             brw_q, brw_d;
    logic             amsb_q, amsb_d;
    logic             bmsb_q, bmsb_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
    logic             ovf_q, ovf_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             bitD;
    logic             bitBout;
    logic             lastBit;

    Full_Sub u_full_sub (
        .X    (sa_q[0]),
        .Y    (sb_q[0]),
        .Bin  (brw_q),
        .D    (bitD),
        .Bout (bitBout)
    );

    assign lastBit = (cnt_q == CW'(WIDTH - 1));

    // Next-state logic: load operands on an accepted start, shift one bit per
    // cycle while busy, and publish the result on the last bit.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        res_d   = res_q;
        brw_d   = brw_q;
        amsb_d  = amsb_q;
        bmsb_d  = bmsb_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
        ovf_d   = ovf_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                busy_d = 1'b0;
                if (start) begin
                    sa_d    = a;
                    sb_d    = b;
                    brw_d   = bin;
                    amsb_d  = a[WIDTH-1];
                    bmsb_d  = b[WIDTH-1];
                    cnt_d   = '0;
                    res_d   = '0;
                    busy_d  = 1'b1;
                    state_d = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                res_d = {bitD, res_q[WIDTH-1:1]};
                sa_d  = sa_q >> 1;
                sb_d  = sb_q >> 1;
                brw_d = bitBout;
                cnt_d = cnt_q + CW'(1);
                if (lastBit) begin
                    diff_d  = {bitD, res_q[WIDTH-1:1]};
                    bout_d  = bitBout;
                    ovf_d   = (amsb_q != bmsb_q) && (bitD != amsb_q);
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sa_q    <= '0;
            sb_q    <= '0;
            res_q   <= '0;
            brw_q   <= 1'b0;
            amsb_q  <= 1'b0;
            bmsb_q  <= 1'b0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            res_q   <= res_d;
            brw_q   <= brw_d;
            amsb_q  <= amsb_d;
            bmsb_q  <= bmsb_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign diff       = diff_q;
    assign borrow_out = bout_q;
    assign ovf        = ovf_q;

endmodule

// File: tb/tb_serial_sub.sv
// Testbench for serial_sub: directed and random operations at WIDTH=8 plus an
// exhaustive sweep at WIDTH=4, checked against an arithmetic reference model.
module tb_serial_sub;

    logic       clk;
    logic       rst_n;

    logic       start8;
    logic [7:0] a8;
    logic [7:0] b8;
    logic       bin8;
    logic       busy8;
    logic       done8;
    logic [7:0] diff8;
    logic       borrow8;
    logic       ovf8;

    logic       start4;
    logic [3:0] a4;
    logic [3:0] b4;
    logic       bin4;
    logic       busy4;
    logic       done4;
    logic [3:0] diff4;
    logic       borrow4;
    logic       ovf4;

    int errors;
    int checks;

    serial_sub #(.WIDTH(8)) dut8 (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start8),
        .a          (a8),
        .b          (b8),
        .bin        (bin8),
        .busy       (busy8),
        .done       (done8),
        .diff       (diff8),
        .borrow_out (borrow8),
        .ovf        (ovf8)
    );

    serial_sub #(.WIDTH(4)) dut4 (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start4),
        .a          (a4),
        .b          (b4),
        .bin        (bin4),
        .busy       (busy4),
        .done       (done4),
        .diff       (diff4),
        .borrow_out (borrow4),
        .ovf        (ovf4)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain integer arithmetic of a - b - bin, wrapped to w bits,
    // with borrow from the unsigned sign and overflow from the signed range.
    task automatic refModel(input int w, input int av, input int bv, input int bi,
                            output int d, output bit br, output bit ov);
        int r;
        int sa;
        int sb;
        int sr;
        r  = av - bv - bi;
        d  = r & ((1 << w) - 1);
        br = (r < 0);
        sa = (av >= (1 << (w - 1))) ? av - (1 << w) : av;
        sb = (bv >= (1 << (w - 1))) ? bv - (1 << w) : bv;
        sr = sa - sb - bi;
        ov = (sr > (1 << (w - 1)) - 1) || (sr < -(1 << (w - 1)));
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic getBusy(input bit sel);
        return sel ? busy4 : busy8;
    endfunction

    function automatic logic getDone(input bit sel);
        return sel ? done4 : done8;
    endfunction

    // Issue one operation on the selected instance, wait for done with a bound,
    // then compare latency, busy duration and the held results with the model.
    task automatic applyStimulus(input bit sel, input int av, input int bv, input int bi,
                                 input string tag);
        int  w;
        int  k;
        int  busyCnt;
        bit  seen;
        int  ed;
        bit  eb;
        bit  eo;
        w = sel ? 4 : 8;
        @(negedge clk);
        if (sel) begin
            a4 = av[3:0]; b4 = bv[3:0]; bin4 = bi[0]; start4 = 1'b1;
        end else begin
            a8 = av[7:0]; b8 = bv[7:0]; bin8 = bi[0]; start8 = 1'b1;
        end
        k = 0;
        busyCnt = 0;
        seen = 1'b0;
        while (!seen && k < 40) begin
            @(negedge clk);
            k++;
            if (k == 1) begin
                start4 = 1'b0;
                start8 = 1'b0;
            end
            if (getBusy(sel)) busyCnt++;
            if (getDone(sel)) seen = 1'b1;
        end
        refModel(w, av, bv, bi, ed, eb, eo);
        checkOutput({tag, ".doneSeen"}, 32'(seen), 32'd1);
        checkOutput({tag, ".latency"}, 32'(k), 32'(w + 1));
        checkOutput({tag, ".busyCycles"}, 32'(busyCnt), 32'(w));
        if (sel) begin
            checkOutput({tag, ".diff"}, {28'd0, diff4}, 32'(ed));
            checkOutput({tag, ".borrow"}, {31'd0, borrow4}, 32'(eb));
            checkOutput({tag, ".ovf"}, {31'd0, ovf4}, 32'(eo));
        end else begin
            checkOutput({tag, ".diff"}, {24'd0, diff8}, 32'(ed));
            checkOutput({tag, ".borrow"}, {31'd0, borrow8}, 32'(eb));
            checkOutput({tag, ".ovf"}, {31'd0, ovf8}, 32'(eo));
        end
    endtask

    // Directed sequence: reset, arithmetic corner cases, asynchronous reset
    // mid-operation, back-to-back issue, random operands and a full 4-bit sweep.
    initial begin
        int  k;
        bit  seen;
        int  doneCnt;
        errors = 0;
        checks = 0;
        rst_n  = 1'b0;
        start8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0;
        start4 = 1'b0; a4 = '0; b4 = '0; bin4 = 1'b0;

        repeat (2) @(negedge clk);
        checkOutput("reset.busy",   {31'd0, busy8},   32'd0);
        checkOutput("reset.done",   {31'd0, done8},   32'd0);
        checkOutput("reset.diff",   {24'd0, diff8},   32'd0);
        checkOutput("reset.borrow", {31'd0, borrow8}, 32'd0);
        checkOutput("reset.ovf",    {31'd0, ovf8},    32'd0);
        rst_n = 1'b1;

        applyStimulus(1'b0, 100, 37, 0, "op100m37");
        applyStimulus(1'b0, 5, 10, 0, "op5m10");
        applyStimulus(1'b0, 0, 0, 1, "op0m0b1");
        applyStimulus(1'b0, 8'h80, 8'h01, 0, "op80m01");

        // Asynchronous reset during the fourth shift cycle.
        @(negedge clk);
        a8 = 8'd50; b8 = 8'd20; bin8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("midop.busyBefore", {31'd0, busy8}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midop.busy",   {31'd0, busy8},   32'd0);
        checkOutput("midop.done",   {31'd0, done8},   32'd0);
        checkOutput("midop.diff",   {24'd0, diff8},   32'd0);
        checkOutput("midop.borrow", {31'd0, borrow8}, 32'd0);
        checkOutput("midop.ovf",    {31'd0, ovf8},    32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        doneCnt = 0;
        repeat (12) begin
            @(negedge clk);
            if (done8) doneCnt++;
        end
        checkOutput("midop.noDone", 32'(doneCnt), 32'd0);
        applyStimulus(1'b0, 200, 199, 0, "op200m199");

        // Back-to-back: start held high, operands changed while busy.
        @(negedge clk);
        a8 = 8'd9; b8 = 8'd4; bin8 = 1'b0; start8 = 1'b1;
        @(posedge clk);
        #1;
        a8 = 8'd3; b8 = 8'd3;
        k = 0;
        seen = 1'b0;
        while (!seen && k < 40) begin
            @(negedge clk);
            k++;
            if (done8) seen = 1'b1;
        end
        checkOutput("b2b.first.latency", 32'(k), 32'd9);
        checkOutput("b2b.first.diff", {24'd0, diff8}, 32'd5);
        k = 0;
        seen = 1'b0;
        while (!seen && k < 40) begin
            @(negedge clk);
            k++;
            if (k == 1) begin
                start8 = 1'b0;
                a8 = 8'($urandom);
                b8 = 8'($urandom);
            end
            if (done8) seen = 1'b1;
        end
        checkOutput("b2b.spacing", 32'(k), 32'd9);
        checkOutput("b2b.second.diff", {24'd0, diff8}, 32'd0);
        checkOutput("b2b.second.borrow", {31'd0, borrow8}, 32'd0);

        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b0, int'($urandom_range(255)), int'($urandom_range(255)),
                          int'($urandom_range(1)), "rand8");
        end

        for (int av = 0; av < 16; av++) begin
            for (int bv = 0; bv < 16; bv++) begin
                for (int bi = 0; bi < 2; bi++) begin
                    applyStimulus(1'b1, av, bv, bi, "sweep4");
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/serial_sub.md
Name: serial_sub

Overview:
- Bit-serial, LSB-first subtractor that computes A - B - Bin over WIDTH clock cycles.
- Reuses the existing one-bit Full_Sub cell as its only datapath element, plus a registered borrow.
- Sits downstream of Full_Sub in the arithmetic library. It is the first sequential consumer of that cell and trades area for latency.
- Uses a start/busy/done handshake so a controller can issue operations back-to-back.

Parameters:
- WIDTH, 8, operand and result width in bits (must be >= 2).

Ports:
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request a new operation; sampled only when not busy.
- a  input  WIDTH  minuend; captured on the accepting edge.
- b  input  WIDTH  subtrahend; captured on the accepting edge.
- bin  input  1  borrow-in; captured on the accepting edge.
- busy  output  1  high while bits are being processed.
- done  output  1  single-cycle pulse when the result becomes valid.
- diff  output  WIDTH  result A-B-Bin mod 2^WIDTH; held stable until the next accepted start.
- borrow_out  output  1  final borrow (unsigned A < B+Bin); held with diff.
- ovf  output  1  signed overflow flag; held with diff.

Behaviour:
- Reset (rst_n low, asynchronous, any time): state=IDLE; busy, done, diff, borrow_out, ovf, bit counter, shift registers and borrow register all 0. Any operation in flight is discarded with no done pulse. Operation resumes on the first rising edge after rst_n rises.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - start=1 at an edge: load sa<=a, sb<=b, brw<=bin, cnt<=0, busy<=1, go to SHIFT.
  - start=0: stay in IDLE.
- SHIFT, each edge:
  - Full_Sub(X=sa[0], Y=sb[0], Bin=brw) gives D and Bout.
  - D is shifted into the result register from the MSB side; sa and sb shift right by one.
  - brw<=Bout; cnt<=cnt+1.
  - On the edge where cnt==WIDTH-1: write diff from the completed result, borrow_out<=Bout, ovf<=(a_msb!=b_msb)&&(D_msb!=a_msb) using the captured operand MSBs. Then busy<=0, done<=1, go to DONE.
- DONE (lasts exactly one cycle, done=1):
  - start=1: accept new operands exactly as in IDLE (back-to-back, no bubble); done falls.
  - start=0: go to IDLE; done falls.
- start while busy=1 is ignored; operands and bin are not re-sampled.
- Latency: if start is accepted at edge E0, done is high in the cycle following edge E0+WIDTH (8 edges for WIDTH=8). Throughput is one operation per WIDTH+1 cycles.
- diff, borrow_out and ovf change only on the completing edge or on reset. Their values are undefined-free: they stay 0 until the first completion.
- Counter width is clog2(WIDTH). The counter never wraps because it is cleared at load.
- bin=1 with a=b=0 must yield all-ones with borrow_out=1 (wrap-around).

Decomposition:
- Package serial_sub_pkg holds:
  - the state enum (IDLE, SHIFT, DONE);
  - the default WIDTH constant;
  - a function computing the counter width.
- Sub-module: exactly one instance of the existing Full_Sub cell (ports X, Y, Bin, D, Bout), wired combinationally between the shift-register LSBs and the borrow register.
- No other hierarchy.

Test Plan:
- a=100, b=37, bin=0, start pulsed → done 8 edges after acceptance; diff=63, borrow_out=0, ovf=0; busy high exactly 8 cycles.
- a=5, b=10, bin=0 → diff=251 (0xFB), borrow_out=1, ovf=0.
- a=0, b=0, bin=1 → diff=255, borrow_out=1; a=0x80, b=0x01, bin=0 → diff=0x7F, borrow_out=0, ovf=1.
- Start held high continuously with a=9,b=4 then a=3,b=3 → results 5 then 0 on consecutive done pulses spaced 9 cycles apart; operand changes while busy have no effect.
- rst_n pulsed low at the 4th SHIFT cycle → all outputs 0 immediately (asynchronous), no done pulse. A subsequent start with a=200, b=199 → diff=1, borrow_out=0.
- Exhaustive sweep at WIDTH=4 over all a, b, bin → every diff, borrow_out and ovf matches a reference model of (a-b-bin) mod 16.
